// File: rtl/types_pkg.sv
// types_pkg: shared types and constants for the rename slice.
//   decode_data  - decoded instruction from decode (rs1, rs2, rd, rd_we, fu, opcode, func3, func7, imm)
//   rename_data  - renamed instruction sent to dispatch (fu, ps1, ps2, pd_new, pd_old, opcode, func3, func7, imm)
//   FU_*         - functional-unit encoding
//   fl_inc()     - free-list pointer increment with wrap at FREE_DEPTH-1
package types_pkg;
  localparam int ARCH_REGS  = 32;
  localparam int PHYS_REGS  = 128;
  localparam int FREE_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int PREG_W     = 7;
  localparam int AREG_W     = 5;

  localparam logic [1:0] FU_NONE = 2'b00;
  localparam logic [1:0] FU_ALU  = 2'b01;
  localparam logic [1:0] FU_BR   = 2'b10;
  localparam logic [1:0] FU_MEM  = 2'b11;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [AREG_W-1:0] areg_t;
  // Free-list pointers and occupancy (0..96) share one 7-bit type.
  typedef logic [6:0]        flptr_t;

  localparam flptr_t FL_LAST  = flptr_t'(FREE_DEPTH - 1);
  localparam flptr_t FL_DEPTH = flptr_t'(FREE_DEPTH);

  typedef struct packed {
    areg_t       rs1;
    areg_t       rs2;
    areg_t       rd;
    logic        rd_we;
    logic [1:0]  fu;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
  } decode_data;

  typedef struct packed {
    logic [1:0]  fu;
    preg_t       ps1;
    preg_t       ps2;
    preg_t       pd_new;
    preg_t       pd_old;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
  } rename_data;

  function automatic flptr_t fl_inc(input flptr_t p);
    return (p == FL_LAST) ? '0 : p + 7'd1;
  endfunction
endpackage

// File: rtl/rename_if.sv
// rename_if: decode->rename->dispatch handshake plus ROB commit and branch
// resolution signals.
//   master: drives valid_in/data_in, ready_out, commit_*, branch_resolved, mispredict
//   slave : the rename stage itself
interface rename_if;
  import types_pkg::*;

  logic       valid_in;
  decode_data data_in;
  logic       ready_in;
  logic       valid_out;
  rename_data data_out;
  logic       ready_out;
  logic       commit_valid;
  preg_t      commit_pd_old;
  logic       branch_resolved;
  logic       mispredict;

  modport master (
    output valid_in, data_in, ready_out, commit_valid, commit_pd_old,
           branch_resolved, mispredict,
    input  ready_in, valid_out, data_out
  );

  modport slave (
    input  valid_in, data_in, ready_out, commit_valid, commit_pd_old,
           branch_resolved, mispredict,
    output ready_in, valid_out, data_out
  );
endinterface

// File: rtl/rename_free_list.sv
// free_list: circular buffer of free physical registers.
//   push/push_preg       - return a preg at tail (commit)
//   pop/pop_preg         - pop_preg is the preg at head; pop consumes it
//   restore/restore_head - rewind head to a checkpoint; the pregs between the
//                          checkpoint and the current head become free again
//   head, count          - current head pointer and number of free entries
module free_list
  import types_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  preg_t  push_preg,
  input  logic   pop,
  output preg_t  pop_preg,
  input  logic   restore,
  input  flptr_t restore_head,
  output flptr_t head,
  output flptr_t count
);
  preg_t  entries [FREE_DEPTH];
  flptr_t tail;
  flptr_t rollback;

  // Entries allocated since the checkpoint: (head - restore_head) mod 96.
  // 7-bit modular arithmetic is exact because the true result is < 96.
  assign rollback = (head >= restore_head) ? (head - restore_head)
                                           : (head + FL_DEPTH - restore_head);
  assign pop_preg = entries[head];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FREE_DEPTH; i++) entries[i] <= preg_t'(ARCH_REGS + i);
      head  <= '0;
      tail  <= '0;
      count <= FL_DEPTH;
    end else begin
      if (push) begin
        entries[tail] <= push_preg;
        tail          <= fl_inc(tail);
      end
      if (restore) begin
        head  <= restore_head;
        count <= count + rollback + {6'b0, push};
      end else begin
        if (pop) head <= fl_inc(head);
        count <= count + {6'b0, push} - {6'b0, pop};
      end
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(push && count == FL_DEPTH));
endmodule

// File: rtl/rename.sv
// rename: in-order register rename stage between decode and dispatch.
// Owns the map table, the free list and a single branch checkpoint.
//   clk, reset - clock, synchronous active-high reset
//   bus        - rename_if.slave: decode handshake (valid_in/data_in/ready_in),
//                dispatch handshake (valid_out/data_out/ready_out), commit
//                (commit_valid/commit_pd_old), branch_resolved, mispredict
module rename
  import types_pkg::*;
(
  input logic     clk,
  input logic     reset,
  rename_if.slave bus
);
  preg_t      map_p0  [ARCH_REGS];
  preg_t      ckpt_map[ARCH_REGS];
  flptr_t     ckpt_head;
  logic       ckpt_busy;

  decode_data din;
  logic       needs_dest;
  logic       is_br;
  logic       ready;
  logic       accept;
  logic       pop;
  preg_t      fl_preg;
  flptr_t     fl_head;
  flptr_t     fl_count;
  flptr_t     head_after;
  rename_data rn;

  rename_data data_p1;
  logic       vld_p1;

  // ---- stage p0: map lookup and preg allocation ----
  assign din        = bus.data_in;
  assign needs_dest = din.rd_we && (din.rd != '0);
  assign is_br      = (din.fu == FU_BR);
  // Pop eligibility uses the registered count only, so a same-cycle commit
  // cannot rescue an empty free list.
  assign ready      = (!vld_p1 || bus.ready_out) && !bus.mispredict &&
                      (!needs_dest || fl_count != '0) && !(is_br && ckpt_busy);
  assign accept     = bus.valid_in && ready;
  assign pop        = accept && needs_dest;
  assign head_after = pop ? fl_inc(fl_head) : fl_head;

  always_comb begin
    rn        = '0;
    rn.fu     = din.fu;
    rn.ps1    = map_p0[din.rs1];
    rn.ps2    = map_p0[din.rs2];
    rn.pd_new = needs_dest ? fl_preg : '0;
    rn.pd_old = needs_dest ? map_p0[din.rd] : '0;
    rn.opcode = din.opcode;
    rn.func3  = din.func3;
    rn.func7  = din.func7;
    rn.imm    = din.imm;
  end

  free_list u_free_list (
    .clk          (clk),
    .reset        (reset),
    .push         (bus.commit_valid),
    .push_preg    (bus.commit_pd_old),
    .pop          (pop),
    .pop_preg     (fl_preg),
    .restore      (bus.mispredict),
    .restore_head (ckpt_head),
    .head         (fl_head),
    .count        (fl_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        map_p0[i]   <= preg_t'(i);
        ckpt_map[i] <= preg_t'(i);
      end
      ckpt_head <= '0;
      ckpt_busy <= 1'b0;
    end else if (bus.mispredict) begin
      for (int i = 0; i < ARCH_REGS; i++) map_p0[i] <= ckpt_map[i];
      ckpt_busy <= 1'b0;
    end else begin
      if (pop) map_p0[din.rd] <= fl_preg;
      if (accept && is_br) begin
        // Snapshot reflects the branch's own destination write, if any.
        for (int i = 0; i < ARCH_REGS; i++)
          ckpt_map[i] <= (pop && din.rd == areg_t'(i)) ? fl_preg : map_p0[i];
        ckpt_head <= head_after;
        ckpt_busy <= 1'b1;
      end else if (bus.branch_resolved) begin
        ckpt_busy <= 1'b0;
      end
    end
  end

  // ---- stage p1: output register toward dispatch ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (bus.mispredict) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= rn;
    end else if (bus.ready_out) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.ready_in  = ready;
  assign bus.valid_out = vld_p1;
  assign bus.data_out  = data_p1;
endmodule

// File: tb/tb_rename.sv
// tb_rename: directed self-checking bench for the rename stage.
module tb_rename;
  import types_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  rename_if bus();

  rename dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic decode_data mk(input logic [1:0] fu, input logic we,
                                    input areg_t rd, input areg_t rs1, input areg_t rs2);
    decode_data d;
    d        = '0;
    d.fu     = fu;
    d.rd_we  = we;
    d.rd     = rd;
    d.rs1    = rs1;
    d.rs2    = rs2;
    d.opcode = 7'h33;
    d.func3  = 3'd5;
    d.func7  = 7'h20;
    d.imm    = 32'hDEAD0000 | {27'b0, rd};
    return d;
  endfunction

  task automatic do_reset();
    reset               = 1'b1;
    bus.valid_in        = 1'b0;
    bus.data_in         = '0;
    bus.ready_out       = 1'b1;
    bus.commit_valid    = 1'b0;
    bus.commit_pd_old   = '0;
    bus.branch_resolved = 1'b0;
    bus.mispredict      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Presents one instruction, expects it to be accepted at the next edge.
  task automatic accept_op(input string tag, input decode_data d);
    bus.valid_in = 1'b1;
    bus.data_in  = d;
    #1;
    check(tag, 32'(bus.ready_in), 1);
    tick();
    bus.valid_in = 1'b0;
  endtask

  preg_t    fq[$];
  preg_t    pend[$];
  preg_t    map_m[ARCH_REGS];
  bit [127:0] inuse;

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset state
    do_reset();
    check("rst_valid_out", 32'(bus.valid_out), 0);
    check("rst_data_out", 32'(bus.data_out.pd_new) | 32'(bus.data_out.imm), 0);
    check("rst_count", 32'(dut.fl_count), 96);
    #1;
    check("rst_ready_in", 32'(bus.ready_in), 1);

    // Basic rename
    accept_op("basic_rdy0", mk(FU_ALU, 1'b1, 5'd5, 5'd1, 5'd2));
    check("basic_valid", 32'(bus.valid_out), 1);
    check("basic_ps1", 32'(bus.data_out.ps1), 1);
    check("basic_ps2", 32'(bus.data_out.ps2), 2);
    check("basic_pd_new", 32'(bus.data_out.pd_new), 32);
    check("basic_pd_old", 32'(bus.data_out.pd_old), 5);
    check("basic_fu", 32'(bus.data_out.fu), 1);
    check("basic_imm", bus.data_out.imm, 32'hDEAD0005);
    accept_op("basic_rdy1", mk(FU_ALU, 1'b1, 5'd5, 5'd3, 5'd5));
    check("basic2_ps2", 32'(bus.data_out.ps2), 32);
    check("basic2_pd_new", 32'(bus.data_out.pd_new), 33);
    check("basic2_pd_old", 32'(bus.data_out.pd_old), 32);
    tick();
    check("basic_drain_valid", 32'(bus.valid_out), 0);
    check("basic_count", 32'(dut.fl_count), 94);

    // Reset mid-operation discards checkpoint and pending output
    accept_op("mid_rdy_br", mk(FU_BR, 1'b0, 5'd0, 5'd0, 5'd0));
    accept_op("mid_rdy_op", mk(FU_ALU, 1'b1, 5'd6, 5'd0, 5'd0));
    check("mid_valid_before", 32'(bus.valid_out), 1);
    do_reset();
    check("mid_valid_after", 32'(bus.valid_out), 0);
    check("mid_data_after", 32'(bus.data_out.pd_new), 0);
    check("mid_count_after", 32'(dut.fl_count), 96);
    bus.valid_in = 1'b1;
    bus.data_in  = mk(FU_BR, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    check("mid_br_ready", 32'(bus.ready_in), 1);
    bus.valid_in = 1'b0;
    accept_op("mid_rdy_op2", mk(FU_ALU, 1'b1, 5'd6, 5'd5, 5'd0));
    check("mid_ps1", 32'(bus.data_out.ps1), 5);
    check("mid_pd_new", 32'(bus.data_out.pd_new), 32);

    // Backpressure
    do_reset();
    bus.ready_out = 1'b0;
    accept_op("bp_rdy0", mk(FU_ALU, 1'b1, 5'd1, 5'd0, 5'd0));
    check("bp_pd0", 32'(bus.data_out.pd_new), 32);
    bus.valid_in = 1'b1;
    bus.data_in  = mk(FU_ALU, 1'b1, 5'd2, 5'd1, 5'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready_low", 32'(bus.ready_in), 0);
      tick();
      check("bp_hold_valid", 32'(bus.valid_out), 1);
      check("bp_hold_pd", 32'(bus.data_out.pd_new), 32);
      check("bp_hold_count", 32'(dut.fl_count), 95);
    end
    bus.ready_out = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.ready_in), 1);
    tick();
    check("bp_pd1", 32'(bus.data_out.pd_new), 33);
    check("bp_ps1_1", 32'(bus.data_out.ps1), 32);
    bus.data_in = mk(FU_ALU, 1'b1, 5'd3, 5'd2, 5'd0);
    tick();
    check("bp_pd2", 32'(bus.data_out.pd_new), 34);
    check("bp_ps1_2", 32'(bus.data_out.ps1), 33);
    bus.valid_in = 1'b0;
    tick();
    check("bp_drain_valid", 32'(bus.valid_out), 0);
    check("bp_count", 32'(dut.fl_count), 93);

    // Free-list exhaustion
    do_reset();
    bus.valid_in = 1'b1;
    for (int i = 0; i < 96; i++) begin
      bus.data_in = mk(FU_ALU, 1'b1, areg_t'((i % 31) + 1), 5'd0, 5'd0);
      tick();
    end
    check("ex_last_pd", 32'(bus.data_out.pd_new), 127);
    check("ex_count0", 32'(dut.fl_count), 0);
    bus.data_in = mk(FU_ALU, 1'b1, 5'd9, 5'd0, 5'd0);
    #1;
    check("ex_dest_stall", 32'(bus.ready_in), 0);
    bus.data_in = mk(FU_BR, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    check("ex_branch_ok", 32'(bus.ready_in), 1);
    bus.data_in = mk(FU_MEM, 1'b0, 5'd0, 5'd1, 5'd2);
    #1;
    check("ex_store_ok", 32'(bus.ready_in), 1);
    bus.data_in = mk(FU_ALU, 1'b1, 5'd0, 5'd1, 5'd2);
    #1;
    check("ex_x0_ok", 32'(bus.ready_in), 1);
    bus.data_in       = mk(FU_ALU, 1'b1, 5'd9, 5'd0, 5'd0);
    bus.commit_valid  = 1'b1;
    bus.commit_pd_old = 7'd7;
    #1;
    check("ex_push_no_pop", 32'(bus.ready_in), 0);
    tick();
    bus.commit_valid = 1'b0;
    check("ex_no_accept", 32'(bus.valid_out), 0);
    check("ex_count1", 32'(dut.fl_count), 1);
    #1;
    check("ex_ready_after_commit", 32'(bus.ready_in), 1);
    tick();
    bus.valid_in = 1'b0;
    check("ex_reuse_pd", 32'(bus.data_out.pd_new), 7);
    check("ex_reuse_old", 32'(bus.data_out.pd_old), 102);
    tick();
    check("ex_count_end", 32'(dut.fl_count), 0);

    // Mispredict recovery
    do_reset();
    accept_op("mp_rdy_br", mk(FU_BR, 1'b0, 5'd0, 5'd1, 5'd2));
    check("mp_br_fu", 32'(bus.data_out.fu), 2);
    accept_op("mp_rdy_r3", mk(FU_ALU, 1'b1, 5'd3, 5'd0, 5'd0));
    check("mp_pd3", 32'(bus.data_out.pd_new), 32);
    accept_op("mp_rdy_r4", mk(FU_ALU, 1'b1, 5'd4, 5'd0, 5'd0));
    check("mp_pd4", 32'(bus.data_out.pd_new), 33);
    check("mp_count_pre", 32'(dut.fl_count), 94);
    bus.mispredict = 1'b1;
    bus.valid_in   = 1'b1;
    bus.data_in    = mk(FU_ALU, 1'b1, 5'd5, 5'd3, 5'd4);
    #1;
    check("mp_no_accept", 32'(bus.ready_in), 0);
    tick();
    bus.mispredict = 1'b0;
    check("mp_valid_out", 32'(bus.valid_out), 0);
    check("mp_count", 32'(dut.fl_count), 96);
    bus.data_in = mk(FU_BR, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    check("mp_ckpt_free", 32'(bus.ready_in), 1);
    bus.data_in = mk(FU_ALU, 1'b1, 5'd5, 5'd3, 5'd4);
    #1;
    tick();
    bus.valid_in = 1'b0;
    check("mp_ps1", 32'(bus.data_out.ps1), 3);
    check("mp_ps2", 32'(bus.data_out.ps2), 4);
    check("mp_pd_new", 32'(bus.data_out.pd_new), 32);
    check("mp_pd_old", 32'(bus.data_out.pd_old), 5);

    // Mispredict with a same-cycle commit
    do_reset();
    accept_op("mc_rdy_r10", mk(FU_ALU, 1'b1, 5'd10, 5'd0, 5'd0));
    accept_op("mc_rdy_br", mk(FU_BR, 1'b0, 5'd0, 5'd0, 5'd0));
    accept_op("mc_rdy_r3", mk(FU_ALU, 1'b1, 5'd3, 5'd0, 5'd0));
    accept_op("mc_rdy_r4", mk(FU_ALU, 1'b1, 5'd4, 5'd0, 5'd0));
    check("mc_count_pre", 32'(dut.fl_count), 93);
    bus.mispredict    = 1'b1;
    bus.commit_valid  = 1'b1;
    bus.commit_pd_old = 7'd10;
    tick();
    bus.mispredict   = 1'b0;
    bus.commit_valid = 1'b0;
    check("mc_count", 32'(dut.fl_count), 96);
    accept_op("mc_rdy_after", mk(FU_ALU, 1'b1, 5'd11, 5'd3, 5'd10));
    check("mc_ps1", 32'(bus.data_out.ps1), 3);
    check("mc_ps2", 32'(bus.data_out.ps2), 32);
    check("mc_pd_new", 32'(bus.data_out.pd_new), 33);
    check("mc_pd_old", 32'(bus.data_out.pd_old), 11);

    // Checkpoint stall
    do_reset();
    accept_op("cs_rdy_br", mk(FU_BR, 1'b0, 5'd0, 5'd0, 5'd0));
    bus.valid_in = 1'b1;
    bus.data_in  = mk(FU_BR, 1'b0, 5'd0, 5'd0, 5'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("cs_br_stall", 32'(bus.ready_in), 0);
      tick();
    end
    bus.data_in = mk(FU_ALU, 1'b1, 5'd7, 5'd0, 5'd0);
    #1;
    check("cs_alu_ok", 32'(bus.ready_in), 1);
    bus.data_in         = mk(FU_BR, 1'b0, 5'd0, 5'd0, 5'd0);
    bus.branch_resolved = 1'b1;
    #1;
    check("cs_resolve_cycle", 32'(bus.ready_in), 0);
    tick();
    bus.branch_resolved = 1'b0;
    check("cs_no_accept", 32'(bus.valid_out), 0);
    #1;
    check("cs_ready_after", 32'(bus.ready_in), 1);
    tick();
    bus.valid_in = 1'b0;
    check("cs_br_out", 32'(bus.valid_out), 1);
    check("cs_br_fu", 32'(bus.data_out.fu), 2);

    // Wrap-around with a preg scoreboard
    do_reset();
    fq.delete();
    pend.delete();
    for (int p = 32; p < 128; p++) fq.push_back(preg_t'(p));
    for (int r = 0; r < ARCH_REGS; r++) map_m[r] = preg_t'(r);
    inuse = '0;
    for (int p = 0; p < 32; p++) inuse[p] = 1'b1;
    for (int i = 0; i < 288; i++) begin
      areg_t rd;
      areg_t rs1;
      preg_t exp_ps1;
      preg_t exp_new;
      preg_t exp_old;
      preg_t c;
      bit    do_commit;
      rd  = areg_t'((i % 31) + 1);
      rs1 = areg_t'((i * 7) % 32);
      bus.valid_in      = 1'b1;
      bus.data_in       = mk(FU_ALU, 1'b1, rd, rs1, 5'd0);
      do_commit         = pend.size() > 40;
      bus.commit_valid  = do_commit;
      bus.commit_pd_old = do_commit ? pend[0] : '0;
      #1;
      check("wrap_ready", 32'(bus.ready_in), 1);
      exp_ps1   = map_m[rs1];
      exp_new   = fq.pop_front();
      exp_old   = map_m[rd];
      map_m[rd] = exp_new;
      pend.push_back(exp_old);
      if (do_commit) begin
        c = pend.pop_front();
        fq.push_back(c);
        inuse[c] = 1'b0;
      end
      tick();
      bus.commit_valid = 1'b0;
      check("wrap_dup", 32'(inuse[bus.data_out.pd_new]), 0);
      inuse[bus.data_out.pd_new] = 1'b1;
      check("wrap_ps1", 32'(bus.data_out.ps1), 32'(exp_ps1));
      check("wrap_pd_new", 32'(bus.data_out.pd_new), 32'(exp_new));
      check("wrap_pd_old", 32'(bus.data_out.pd_old), 32'(exp_old));
    end
    bus.valid_in = 1'b0;
    check("wrap_count_mid", 32'(dut.fl_count), 32'(fq.size()));
    while (pend.size() > 0) begin
      bus.commit_valid  = 1'b1;
      bus.commit_pd_old = pend.pop_front();
      tick();
    end
    bus.commit_valid = 1'b0;
    tick();
    check("wrap_count_end", 32'(dut.fl_count), 96);
    check("wrap_head_zero", 32'(dut.u_free_list.head), 0);
    check("wrap_tail_zero", 32'(dut.u_free_list.tail), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
